branch_predict_unit: RTL

// - Bimodal branch predictor plus branch resolver. IF stage looks up a PC-indexed table of saturating counters to get a taken/not-taken prediction.
// - EX stage evaluates the funct3 condition against comparator flags, compares the outcome with the prediction carried down the pipe, and flags a mispredict.
// - Trains the table one edge after resolution and keeps wrapping statistics counters. Sits between IF (lookup) and EX (resolve); the hazard unit consumes mispredict_o.

---
 rtl/core_pkg.sv | 21 ++
 rtl/br_cond_eval.sv | 28 ++
 rtl/branch_predict_unit.sv | 104 ++++++++++
 3 files changed

// File: rtl/core_pkg.sv
// Shared branch-unit constants: RISC-V branch funct3 encodings, 2-bit counter states, BHT index LSB.
package core_pkg;

  localparam logic [2:0] FUNCT3_BRANCH_BEQ  = 3'b000;
  localparam logic [2:0] FUNCT3_BRANCH_BNE  = 3'b001;
  localparam logic [2:0] FUNCT3_BRANCH_BLT  = 3'b100;
  localparam logic [2:0] FUNCT3_BRANCH_BGE  = 3'b101;
  localparam logic [2:0] FUNCT3_BRANCH_BLTU = 3'b110;
  localparam logic [2:0] FUNCT3_BRANCH_BGEU = 3'b111;

  typedef enum logic [1:0] {
    SNT = 2'd0,
    WNT = 2'd1,
    WT  = 2'd2,
    ST  = 2'd3
  } bht_cnt_e;

  // Instructions are word aligned, so the table index starts above pc[1:0].
  localparam int BHT_IDX_LSB = 2;

endpackage

// File: rtl/br_cond_eval.sv
// Branch condition decode: maps funct3 and comparator flags to taken/not-taken.
// Purely combinational; cond_ok_o drops for the two funct3 codes that are not branches.
module br_cond_eval
  import core_pkg::*;
(
  input  logic [2:0] funct3_i,
  input  logic       br_eq_i,
  input  logic       br_lt_i,
  input  logic       br_ltu_i,
  output logic       cond_o,
  output logic       cond_ok_o
);

  always_comb begin
    cond_o    = 1'b0;
    cond_ok_o = 1'b1;
    case (funct3_i)
      FUNCT3_BRANCH_BEQ:  cond_o = br_eq_i;
      FUNCT3_BRANCH_BNE:  cond_o = ~br_eq_i;
      FUNCT3_BRANCH_BLT:  cond_o = br_lt_i;
      FUNCT3_BRANCH_BGE:  cond_o = ~br_lt_i;
      FUNCT3_BRANCH_BLTU: cond_o = br_ltu_i;
      FUNCT3_BRANCH_BGEU: cond_o = ~br_ltu_i;
      default:            cond_ok_o = 1'b0;
    endcase
  end

endmodule

// File: rtl/branch_predict_unit.sv
// Bimodal predictor (combinational IF lookup) plus EX branch resolver with mispredict flag.
// Table and statistics train on the edge after an unstalled resolution; no read bypass.
module branch_predict_unit
  import core_pkg::*;
#(
  parameter int XLEN        = 32,
  parameter int BHT_ENTRIES = 64,
  parameter int CNT_BITS    = 2,
  parameter int STAT_W      = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [XLEN-1:0]   if_pc_i,
  output logic              if_pred_taken_o,
  input  logic              ex_valid_i,
  input  logic              ex_stall_i,
  input  logic              ex_branch_i,
  input  logic [XLEN-1:0]   ex_pc_i,
  input  logic [2:0]        ex_funct3_i,
  input  logic              ex_pred_taken_i,
  input  logic              BrEQ_i,
  input  logic              BrLT_i,
  input  logic              BrLTU_i,
  output logic              BranchTaken_o,
  output logic              mispredict_o,
  input  logic              clear_stats_i,
  output logic [STAT_W-1:0] branch_cnt_o,
  output logic [STAT_W-1:0] mispred_cnt_o
);

  localparam int IDX_W = $clog2(BHT_ENTRIES);
  localparam logic [CNT_BITS-1:0] CNT_MAX  = '1;
  localparam logic [CNT_BITS-1:0] CNT_INIT = (CNT_BITS == 2) ? CNT_BITS'(WNT)
                                                             : CNT_BITS'((2 ** (CNT_BITS - 1)) - 1);

  logic [CNT_BITS-1:0] bht_q [BHT_ENTRIES];
  logic [CNT_BITS-1:0] bht_cur;
  logic [CNT_BITS-1:0] bht_d;
  logic [STAT_W-1:0]   branch_cnt_q, branch_cnt_d;
  logic [STAT_W-1:0]   mispred_cnt_q, mispred_cnt_d;
  logic [IDX_W-1:0]    if_idx, ex_idx;
  logic                cond, cond_ok, res, upd;
  logic                unused_pc_bits;

  assign if_idx = if_pc_i[BHT_IDX_LSB +: IDX_W];
  assign ex_idx = ex_pc_i[BHT_IDX_LSB +: IDX_W];
  assign unused_pc_bits = ^{if_pc_i[XLEN-1:IDX_W+BHT_IDX_LSB], if_pc_i[BHT_IDX_LSB-1:0],
                            ex_pc_i[XLEN-1:IDX_W+BHT_IDX_LSB], ex_pc_i[BHT_IDX_LSB-1:0]};

  assign if_pred_taken_o = bht_q[if_idx][CNT_BITS-1];

  br_cond_eval u_cond (
    .funct3_i  (ex_funct3_i),
    .br_eq_i   (BrEQ_i),
    .br_lt_i   (BrLT_i),
    .br_ltu_i  (BrLTU_i),
    .cond_o    (cond),
    .cond_ok_o (cond_ok)
  );

  assign res           = ex_valid_i & ex_branch_i & cond_ok;
  assign BranchTaken_o = res & cond;
  assign mispredict_o  = res & (cond ^ ex_pred_taken_i);
  // A stalled branch is re-presented next cycle; only the unstalled copy trains.
  assign upd           = res & ~ex_stall_i;

  always_comb begin
    bht_cur = bht_q[ex_idx];
    bht_d   = bht_cur;
    if (cond) begin
      if (bht_cur != CNT_MAX) bht_d = bht_cur + CNT_BITS'(1);
    end else begin
      if (bht_cur != '0) bht_d = bht_cur - CNT_BITS'(1);
    end
  end

  always_comb begin
    branch_cnt_d  = branch_cnt_q;
    mispred_cnt_d = mispred_cnt_q;
    if (clear_stats_i) begin
      branch_cnt_d  = '0;
      mispred_cnt_d = '0;
    end else if (upd) begin
      branch_cnt_d = branch_cnt_q + STAT_W'(1);
      if (mispredict_o) mispred_cnt_d = mispred_cnt_q + STAT_W'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < BHT_ENTRIES; i++) bht_q[i] <= CNT_INIT;
      branch_cnt_q  <= '0;
      mispred_cnt_q <= '0;
    end else begin
      if (upd) bht_q[ex_idx] <= bht_d;
      branch_cnt_q  <= branch_cnt_d;
      mispred_cnt_q <= mispred_cnt_d;
    end
  end

  assign branch_cnt_o  = branch_cnt_q;
  assign mispred_cnt_o = mispred_cnt_q;

endmodule
